// File: rtl/procco_seg_pkg.sv
// rtl/procco_seg_pkg.sv - shared state type, blank constants and hex-to-segment table for the scan driver
package procco_seg_pkg;

   typedef enum logic {
      ST_OFF  = 1'b0,
      ST_SCAN = 1'b1
   } seg_state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [7:0] AN_OFF    = 8'hFF;

   // Active-low cathodes, bit 0 = segment a .. bit 6 = segment g
   localparam logic [6:0] HEX7SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
      7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
      7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
      7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
   };

endpackage

// File: rtl/hex7seg_decoder.sv
// rtl/hex7seg_decoder.sv - combinational nibble to active-low seven-segment decoder
module hex7seg_decoder
   import procco_seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   assign seg = HEX7SEG_TABLE[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// rtl/seg_scan_driver.sv - 8-digit multiplexed seven-segment scan driver; SEG_LZB_EN enables leading-zero blanking
module seg_scan_driver
   import procco_seg_pkg::*;
#(
   parameter int SCAN_DIV = 100000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [31:0] data,
   output logic [6:0]  SEG,
   output logic [7:0]  AN,
   output logic        pending,
   output logic        frame_done
);

   localparam int            CW       = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

   seg_state_t    state;
   logic [CW-1:0] presc;
   logic [2:0]    idx;
   logic [31:0]   disp_word;
   logic [31:0]   pend_word;
   logic          terminal;
   logic          boundary;
   logic [3:0]    nibble;
   logic [6:0]    seg_dec;
   logic          digit_lit;
   logic [6:0]    seg_next;
   logic [7:0]    an_next;

   // A slot ends on the last prescaler count; the slot of digit 7 closes the frame.
   assign terminal   = (state == ST_SCAN) && (presc == CNT_LAST);
   assign boundary   = terminal && (idx == 3'd7);
   assign frame_done = boundary;

   assign nibble = disp_word[{idx, 2'b00} +: 4];

   hex7seg_decoder u_dec (
      .nibble (nibble),
      .seg    (seg_dec)
   );

`ifdef SEG_LZB_EN
   // Index of the most significant nonzero nibble; digit 0 when the word is zero.
   function automatic logic [2:0] top_digit(input logic [31:0] w);
      logic [2:0] t;
      t = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (w[4*i +: 4] != 4'h0) t = 3'(i);
      end
      return t;
   endfunction

   assign digit_lit = (idx <= top_digit(disp_word));
`else
   assign digit_lit = 1'b1;
`endif

   // Scan timing: prescaler and digit index advance only while scanning.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_OFF;
         presc <= '0;
         idx   <= '0;
      end else if (state == ST_OFF) begin
         if (load) begin
            state <= ST_SCAN;
            presc <= '0;
            idx   <= '0;
         end
      end else if (terminal) begin
         presc <= '0;
         idx   <= idx + 3'd1;
      end else begin
         presc <= presc + CW'(1);
      end
   end

   // Word handling: loads go live at once from OFF, otherwise only at a frame boundary.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         disp_word <= '0;
         pend_word <= '0;
         pending   <= 1'b0;
      end else if (state == ST_OFF) begin
         if (load) disp_word <= data;
      end else if (boundary) begin
         if (load)         disp_word <= data;
         else if (pending) disp_word <= pend_word;
         pending <= 1'b0;
      end else if (load) begin
         pend_word <= data;
         pending   <= 1'b1;
      end
   end

   // Next drive values: one-hot-low anode for the current digit, or fully blank.
   always_comb begin
      seg_next = SEG_BLANK;
      an_next  = AN_OFF;
      if (state == ST_SCAN && digit_lit) begin
         an_next  = ~(8'd1 << idx);
         seg_next = seg_dec;
      end
   end

   // Registered pin drive, lagging index/display updates by one cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         SEG <= SEG_BLANK;
         AN  <= AN_OFF;
      end else begin
         SEG <= seg_next;
         AN  <= an_next;
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb/tb_seg_scan_driver.sv - self-checking bench for seg_scan_driver against a frame-position model
module tb_seg_scan_driver;

   localparam int DIV   = 4;
   localparam int FRAME = 8 * DIV;

   logic        clk   = 1'b0;
   logic        reset = 1'b1;
   logic        load  = 1'b0;
   logic [31:0] data  = '0;
   logic [6:0]  SEG;
   logic [7:0]  AN;
   logic        pending;
   logic        frame_done;

   seg_scan_driver #(.SCAN_DIV(DIV)) dut (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .data       (data),
      .SEG        (SEG),
      .AN         (AN),
      .pending    (pending),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Model: scanning flag, position within the frame, shown word, queued word.
   bit          m_scan = 1'b0;
   int          m_pos  = 0;
   logic [31:0] m_disp = '0;
   logic [31:0] m_pend = '0;
   bit          m_pv   = 1'b0;
   logic [7:0]  exp_an  = 8'hFF;
   logic [6:0]  exp_seg = 7'h7F;

   bit mon_en   = 1'b0;
   int seen_one = 0;

   function automatic logic [6:0] ref_seg(input logic [3:0] n);
      logic [6:0] on;
      case (n)
         4'h0: on = 7'b0111111;  4'h1: on = 7'b0000110;
         4'h2: on = 7'b1011011;  4'h3: on = 7'b1001111;
         4'h4: on = 7'b1100110;  4'h5: on = 7'b1101101;
         4'h6: on = 7'b1111101;  4'h7: on = 7'b0000111;
         4'h8: on = 7'b1111111;  4'h9: on = 7'b1101111;
         4'hA: on = 7'b1110111;  4'hB: on = 7'b1111100;
         4'hC: on = 7'b0111001;  4'hD: on = 7'b1011110;
         4'hE: on = 7'b1111001;  default: on = 7'b1110001;
      endcase
      return ~on;
   endfunction

   function automatic int lead_digit(input logic [31:0] w);
      int t;
      t = 0;
      for (int i = 0; i < 8; i++) if (w[4*i +: 4] != 4'h0) t = i;
      return t;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic do_load(input logic [31:0] w);
      load = 1'b1;
      data = w;
      step();
      load = 1'b0;
      data = $urandom;
   endtask

   task automatic wait_pos(input int p, input string name);
      int n;
      n = 0;
      while (m_pos != p && n < 4 * FRAME) begin
         step();
         n++;
      end
      check(name, 32'(m_pos), 32'(p));
   endtask

   // Model update on each clock edge; expected pins come from the pre-edge view.
   always @(posedge clk) begin
      int d;
      bit lit;
      if (reset) begin
         m_scan = 1'b0; m_pos = 0; m_disp = '0; m_pend = '0; m_pv = 1'b0;
         exp_an = 8'hFF; exp_seg = 7'h7F;
      end else begin
         exp_an  = 8'hFF;
         exp_seg = 7'h7F;
         if (m_scan) begin
            d   = m_pos / DIV;
            lit = 1'b1;
`ifdef SEG_LZB_EN
            lit = (d <= lead_digit(m_disp));
`endif
            if (lit) begin
               exp_an  = 8'hFF ^ (8'd1 << d);
               exp_seg = ref_seg(m_disp[4*d +: 4]);
            end
         end
         if (!m_scan) begin
            if (load) begin
               m_scan = 1'b1; m_pos = 0; m_disp = data;
            end
         end else if (m_pos == FRAME - 1) begin
            if (load)      m_disp = data;
            else if (m_pv) m_disp = m_pend;
            m_pv  = 1'b0;
            m_pos = 0;
         end else begin
            if (load) begin
               m_pend = data; m_pv = 1'b1;
            end
            m_pos++;
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      check("an", 32'(AN), 32'(exp_an));
      check("seg", 32'(SEG), 32'(exp_seg));
      check("pending", 32'(pending), 32'(m_pv));
      check("frame_done", 32'(frame_done), 32'(m_scan && m_pos == FRAME - 1));
      if (mon_en && AN != 8'hFF && SEG == 7'h79) seen_one++;
   end

   initial begin
      int fd_first;
      int fd_second;
      logic [7:0] an_want;

      // Reset and idle
      repeat (3) step();
      reset = 1'b0;
      repeat (100) step();
      check("idle_an", 32'(AN), 32'h000000FF);
      check("idle_seg", 32'(SEG), 32'h0000007F);
      check("idle_pending", 32'(pending), 32'h0);

      // First frame from OFF: anode walk, digit patterns, frame pulse period
      do_load(32'h89ABCDEF);
      fd_first  = -1;
      fd_second = -1;
      for (int k = 0; k < 70; k++) begin
         if (k >= 1 && k <= 1 + 7 * DIV && (k - 1) % DIV == 0) begin
            an_want = 8'hFF ^ (8'd1 << ((k - 1) / DIV));
            check("walk_an", 32'(AN), 32'(an_want));
         end
         if (k == 1)           check("digit0_F", 32'(SEG), 32'h0E);
         if (k == 1 + 7 * DIV) check("digit7_8", 32'(SEG), 32'h00);
         if (frame_done) begin
            if (fd_first < 0) fd_first = k;
            else if (fd_second < 0) fd_second = k;
         end
         step();
      end
      check("fd_first", 32'(fd_first), 32'd31);
      check("fd_period", 32'(fd_second - fd_first), 32'd32);

      // Mid-frame double load: last word wins at the boundary
      wait_pos(10, "wait_mid");
      mon_en = 1'b1;
      do_load(32'h11111111);
      repeat (3) step();
      do_load(32'h22222222);
      check("pend_set", 32'(pending), 32'h1);
      wait_pos(FRAME - 1, "wait_bnd1");
      check("pend_hold", 32'(pending), 32'h1);
      step();
      check("pend_clr", 32'(pending), 32'h0);
      step();
      check("two_seg", 32'(SEG), 32'h24);
      repeat (2 * FRAME) step();
      mon_en = 1'b0;
      check("ones_never", 32'(seen_one), 32'h0);

      // Load on the exact boundary cycle overrides a queued word
      wait_pos(5, "wait_pos5");
      do_load(32'hDEADBEEF);
      wait_pos(FRAME - 1, "wait_bnd2");
      do_load(32'h00000005);
      check("bnd_pending", 32'(pending), 32'h0);
      step();
      check("bnd_an0", 32'(AN), 32'hFE);
      check("bnd_seg5", 32'(SEG), 32'h12);
      repeat (DIV) step();
`ifdef SEG_LZB_EN
      check("bnd_digit1", 32'(AN), 32'hFF);
`else
      check("bnd_digit1", 32'(SEG), 32'h40);
`endif

      // Reset at digit 4 with a word queued
      wait_pos(2, "wait_pos2");
      do_load(32'h33333333);
      wait_pos(4 * DIV + 1, "wait_dig4");
      reset = 1'b1;
      #1;
      check("rst_an", 32'(AN), 32'hFF);
      check("rst_seg", 32'(SEG), 32'h7F);
      check("rst_pending", 32'(pending), 32'h0);
      check("rst_fd", 32'(frame_done), 32'h0);
      repeat (2) step();
      reset = 1'b0;
      repeat (50) step();
      check("post_rst_blank", 32'(AN), 32'hFF);

      // Leading-zero word from OFF
      do_load(32'h00000A30);
      for (int k = 0; k <= 1 + 3 * DIV; k++) begin
         if (k == 1)           check("lz_d0", 32'(SEG), 32'h40);
         if (k == 1 + DIV)     check("lz_d1", 32'(SEG), 32'h30);
         if (k == 1 + 2 * DIV) check("lz_d2", 32'(SEG), 32'h08);
         if (k == 1 + 3 * DIV) begin
`ifdef SEG_LZB_EN
            check("lz_d3", 32'(AN), 32'hFF);
`else
            check("lz_d3", 32'(AN), 32'hF7);
`endif
         end
         step();
      end

      // Random loads, including boundary-aligned ones
      for (int i = 0; i < 2000; i++) begin
         load = ($urandom_range(0, 15) == 0) || (m_pos == FRAME - 1 && $urandom_range(0, 1) == 1);
         data = $urandom >> (4 * $urandom_range(0, 7));
         step();
      end
      load = 1'b0;
      repeat (4) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
